// File: rtl/peridot_servo_stepgen.sv
// peridot_servo_stepgen
// Step/frame timebase for the PERIDOT RC servo PWM channels. A programmable
// prescaler emits one pwm_timing strobe per step; step_num sweeps
// 0..FRAMESTEPS-1 per frame. pwm_enable is switched only on frame boundaries
// so a running servo never receives a truncated pulse.
// Optional frame interrupt (FRAME/IRQENA/irq): define PERIDOT_SERVO_STEPGEN_IRQ_EN.
module peridot_servo_stepgen #(
  parameter int CLOCKFREQ  = 100000000,
  parameter int STEPFREQ   = 128000,
  parameter int FRAMESTEPS = 2560
) (
  input  logic        clock_sig,
  input  logic        reset_sig,
  input  logic [1:0]  reg_address,
  input  logic        reg_write,
  input  logic [15:0] reg_writedata,
  output logic [15:0] reg_readdata,
  output logic        pwm_enable,
  output logic        pwm_timing,
  output logic [12:0] step_num,
  output logic        frame_start,
  output logic        irq
);

  localparam logic [15:0] DIV_RESET = 16'(CLOCKFREQ / STEPFREQ - 1);
  localparam logic [12:0] LAST_STEP = 13'(FRAMESTEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] div_r;
  logic [15:0] presc_r;
  logic [12:0] step_r;
  logic [12:0] step_next_s;
  logic        enable_r;
  logic        pwm_enable_r;
  logic        pwm_timing_r;
  logic        frame_start_r;
  logic        ctrl_wr_s;
  logic        div_wr_s;
  logic        tick_s;
  logic        frame_end_s;
  logic        irqena_s;
  logic        frame_s;

  assign ctrl_wr_s   = reg_write && (reg_address == 2'd0);
  assign div_wr_s    = reg_write && (reg_address == 2'd2);
  assign tick_s      = (presc_r == 16'd0);
  assign frame_end_s = pwm_timing_r && (step_r == LAST_STEP);

  assign pwm_enable  = pwm_enable_r;
  assign pwm_timing  = pwm_timing_r;
  assign step_num    = step_r;
  assign frame_start = frame_start_r;

  // Step value after the current cycle: advances only once a strobe cycle ends.
  always_comb begin
    step_next_s = step_r;
    if (pwm_timing_r) begin
      if (step_r == LAST_STEP) begin
        step_next_s = 13'd0;
      end else begin
        step_next_s = step_r + 13'd1;
      end
    end else begin
      step_next_s = step_r;
    end
  end

  // Run-state decisions: enable writes start/stop, drain ends at the last step.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (ctrl_wr_s && reg_writedata[0]) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (ctrl_wr_s && !reg_writedata[0]) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (ctrl_wr_s && reg_writedata[0]) begin
          state_next_s = RUN;
        end else if (frame_end_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus the run gate, which follows the next state directly.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_r      <= IDLE;
      pwm_enable_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pwm_enable_r <= (state_next_s != IDLE);
    end
  end

  // Prescaler, strobe and step counter; held at idle values outside RUN/DRAIN.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      presc_r       <= DIV_RESET;
      pwm_timing_r  <= 1'b0;
      frame_start_r <= 1'b0;
      step_r        <= 13'd0;
    end else if ((state_r == IDLE) || (state_next_s == IDLE)) begin
      presc_r       <= div_r;
      pwm_timing_r  <= 1'b0;
      frame_start_r <= 1'b0;
      step_r        <= 13'd0;
    end else begin
      presc_r       <= tick_s ? div_r : (presc_r - 16'd1);
      pwm_timing_r  <= tick_s;
      frame_start_r <= tick_s && (step_next_s == 13'd0);
      step_r        <= step_next_s;
    end
  end

  // Software-visible ENABLE and DIV registers.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      enable_r <= 1'b0;
      div_r    <= DIV_RESET;
    end else begin
      if (ctrl_wr_s) begin
        enable_r <= reg_writedata[0];
      end
      if (div_wr_s) begin
        div_r <= reg_writedata;
      end
    end
  end

`ifdef PERIDOT_SERVO_STEPGEN_IRQ_EN
  logic irqena_r;
  logic irqena_next_s;
  logic frame_r;
  logic frame_next_s;
  logic irq_r;
  logic status_wr_s;

  assign status_wr_s = reg_write && (reg_address == 2'd1);

  // Next FRAME/IRQENA: a frame start beats a simultaneous write-1 clear.
  always_comb begin
    irqena_next_s = irqena_r;
    frame_next_s  = frame_r;
    if (ctrl_wr_s) begin
      irqena_next_s = reg_writedata[1];
    end else begin
      irqena_next_s = irqena_r;
    end
    if (frame_start_r) begin
      frame_next_s = 1'b1;
    end else if (status_wr_s && reg_writedata[0]) begin
      frame_next_s = 1'b0;
    end else begin
      frame_next_s = frame_r;
    end
  end

  // Interrupt registers; irq is registered from the next-state values.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      irqena_r <= 1'b0;
      frame_r  <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      irqena_r <= irqena_next_s;
      frame_r  <= frame_next_s;
      irq_r    <= irqena_next_s && frame_next_s;
    end
  end

  assign irqena_s = irqena_r;
  assign frame_s  = frame_r;
  assign irq      = irq_r;
`else
  assign irqena_s = 1'b0;
  assign frame_s  = 1'b0;
  assign irq      = 1'b0;
`endif

  // Zero-wait register read mux.
  always_comb begin
    reg_readdata = 16'h0000;
    case (reg_address)
      2'd0:    reg_readdata = {pwm_enable_r, 13'd0, irqena_s, enable_r};
      2'd1:    reg_readdata = {15'd0, frame_s};
      2'd2:    reg_readdata = div_r;
      2'd3:    reg_readdata = {3'd0, step_r};
      default: reg_readdata = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_peridot_servo_stepgen.sv
// Self-checking bench for peridot_servo_stepgen: register table, arithmetic
// timing model over directed and randomized run/drain/re-enable scripts,
// DIV change and frame interrupt sequences.
module tb_peridot_servo_stepgen;

  localparam int FS = 2560;
`ifdef PERIDOT_SERVO_STEPGEN_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clock_sig;
  logic        reset_sig;
  logic [1:0]  reg_address;
  logic        reg_write;
  logic [15:0] reg_writedata;
  logic [15:0] reg_readdata;
  logic        pwm_enable;
  logic        pwm_timing;
  logic [12:0] step_num;
  logic        frame_start;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  peridot_servo_stepgen dut (
    .clock_sig    (clock_sig),
    .reset_sig    (reset_sig),
    .reg_address  (reg_address),
    .reg_write    (reg_write),
    .reg_writedata(reg_writedata),
    .reg_readdata (reg_readdata),
    .pwm_enable   (pwm_enable),
    .pwm_timing   (pwm_timing),
    .step_num     (step_num),
    .frame_start  (frame_start),
    .irq          (irq)
  );

  initial clock_sig = 1'b0;
  always #5 clock_sig = ~clock_sig;

  always @(posedge clock_sig) edge_n <= edge_n + 1;

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clock_sig);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    reg_address   = a;
    reg_writedata = d;
    reg_write     = 1'b1;
    tick();
    reg_write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    reg_address = a;
    #1;
    d = reg_readdata;
  endtask

  task automatic do_reset();
    reg_write = 1'b0;
    reset_sig = 1'b1;
    tick();
    tick();
    reset_sig = 1'b0;
    tick();
  endtask

  task automatic check_outs_zero(input string name);
    check({name, ".pwm_enable"}, 32'(pwm_enable), 32'd0);
    check({name, ".pwm_timing"}, 32'(pwm_timing), 32'd0);
    check({name, ".step_num"}, 32'(step_num), 32'd0);
    check({name, ".frame_start"}, 32'(frame_start), 32'd0);
    check({name, ".irq"}, 32'(irq), 32'd0);
  endtask

  // Offset (from the ENABLE=1 write edge) of the edge where the gate drops when
  // the last ENABLE=0 write lands at offset df: just after the first strobe
  // of step FS-1 that happens at or after df. Strobe j lands at offset p*(j+1).
  function automatic int end_off(input int div, input int df);
    int p;
    int j;
    p = div + 1;
    j = (df + p - 1) / p - 1;
    j = j + (FS - 1 - (j % FS));
    return p * (j + 1) + 1;
  endfunction

  // Runs one enable script and compares every cycle to the arithmetic model.
  // d1: disable offset; r1: re-enable offset (0 = none); d2: second disable
  // (0 = none). With a re-enable and no second disable the run stops at stop_off.
  task automatic run_script(input int div, input int d1, input int r1, input int d2,
                            input int stop_off);
    int p, w, df, e, stop_e, dd, cnt, stp;
    bit ends, tim;
    logic [15:0] want, got;
    p = div + 1;
    wr(2'd2, 16'(div));
    check("pre_enable.pwm_enable", 32'(pwm_enable), 32'd0);
    wr(2'd0, 16'h0001);
    w = edge_n;
    ends = (r1 == 0) || (d2 != 0);
    df = (r1 == 0) ? d1 : d2;
    e = w + end_off(div, df);
    stop_e = ends ? e + 4 : w + stop_off;
    while (edge_n < stop_e) begin
      if (edge_n + 1 == w + d1) begin
        reg_address = 2'd0; reg_writedata = 16'h0000; reg_write = 1'b1;
      end else if ((r1 != 0) && (edge_n + 1 == w + r1)) begin
        reg_address = 2'd0; reg_writedata = 16'h0001; reg_write = 1'b1;
      end else if ((d2 != 0) && (edge_n + 1 == w + d2)) begin
        reg_address = 2'd0; reg_writedata = 16'h0000; reg_write = 1'b1;
      end else begin
        reg_write = 1'b0;
      end
      tick();
      dd = edge_n - w;
      if (ends && edge_n >= e) begin
        want = 16'h0000;
      end else begin
        cnt  = (dd < 1) ? 0 : (dd - 1) / p;
        tim  = (dd > 0) && (dd % p == 0);
        stp  = cnt % FS;
        want = {1'b1, tim, tim && (stp == 0), 13'(stp)};
      end
      got = {pwm_enable, pwm_timing, frame_start, step_num};
      check("cycle{en,tim,fs,step}", 32'(got), 32'(want));
    end
    reg_write = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] d;
    int w, n, div, d1, r1, eo;
    int se[4];

    vecs[0]  = '{1'b0, 2'd0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 2'd1, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 2'd2, 16'h0000, 16'd780};
    vecs[3]  = '{1'b0, 2'd3, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 2'd2, 16'h1234, 16'h1234};
    vecs[5]  = '{1'b1, 2'd2, 16'hFFFF, 16'hFFFF};
    vecs[6]  = '{1'b1, 2'd0, 16'h8002, IRQ_ON ? 16'h0002 : 16'h0000};
    vecs[7]  = '{1'b1, 2'd1, 16'h0001, 16'h0000};
    vecs[8]  = '{1'b1, 2'd3, 16'h0ABC, 16'h0000};
    vecs[9]  = '{1'b1, 2'd0, 16'h0000, 16'h0000};
    vecs[10] = '{1'b1, 2'd2, 16'd780, 16'd780};

    reset_sig = 1'b1;
    reg_write = 1'b0;
    reg_address = 2'd0;
    reg_writedata = 16'h0000;
    #2;
    check_outs_zero("reset");
    do_reset();
    check_outs_zero("after_reset");

    // Register table
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, d);
      check($sformatf("regvec%0d", i), 32'(d), 32'(vecs[i].exp));
    end
    check_outs_zero("after_table");

    // DIV=3: drain from step 1000, re-enable at 2000, wrap, drain again
    do_reset();
    run_script(3, 4002, 8002, 14242, 0);
    rd(2'd3, d);
    check("drain_end.STEP", 32'(d), 32'd0);
    rd(2'd0, d);
    check("drain_end.CONTROL", 32'(d), 32'd0);

    // DIV change mid-count
    do_reset();
    wr(2'd2, 16'd3);
    check("divtest.pre_en", 32'(pwm_enable), 32'd0);
    wr(2'd0, 16'h0001);
    w = edge_n;
    check("divtest.en_rise", 32'(pwm_enable), 32'd1);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (edge_n + 1 == w + 6) begin
        reg_address = 2'd2; reg_writedata = 16'd7; reg_write = 1'b1;
      end else begin
        reg_write = 1'b0;
      end
      tick();
      if (pwm_timing) begin
        if (n < 4) se[n] = edge_n - w;
        n++;
      end
    end
    check("divtest.count", 32'(n), 32'd4);
    check("divtest.s0", 32'(se[0]), 32'd4);
    check("divtest.s1", 32'(se[1]), 32'd8);
    check("divtest.s2", 32'(se[2]), 32'd16);
    check("divtest.s3", 32'(se[3]), 32'd24);

    // Frame interrupt
    do_reset();
    wr(2'd2, 16'd0);
    wr(2'd0, 16'h0003);
    w = edge_n;
    rd(2'd0, d);
    check("irqtest.CONTROL", 32'(d), IRQ_ON ? 32'h8003 : 32'h8001);
    tick();
    check("irqtest.fs_first", 32'(frame_start), 32'd1);
    check("irqtest.irq_before", 32'(irq), 32'd0);
    tick();
    check("irqtest.irq_rise", 32'(irq), IRQ_ON ? 32'd1 : 32'd0);
    rd(2'd1, d);
    check("irqtest.status_set", 32'(d), IRQ_ON ? 32'd1 : 32'd0);
    while (edge_n < w + 2561) tick();
    check("irqtest.fs_second", 32'(frame_start), 32'd1);
    wr(2'd1, 16'h0001);
    check("irqtest.set_wins_irq", 32'(irq), IRQ_ON ? 32'd1 : 32'd0);
    rd(2'd1, d);
    check("irqtest.set_wins_status", 32'(d), IRQ_ON ? 32'd1 : 32'd0);
    wr(2'd1, 16'h0001);
    check("irqtest.cleared_irq", 32'(irq), 32'd0);
    rd(2'd1, d);
    check("irqtest.cleared_status", 32'(d), 32'd0);

    // Randomized scripts, each finished by an asynchronous mid-run reset
    for (int t = 0; t < 3; t++) begin
      do_reset();
      div = $urandom_range(1, 0);
      d1  = $urandom_range(FS * (div + 1), 1);
      eo  = end_off(div, d1);
      r1  = 0;
      if (($urandom_range(1, 0) == 1) && (eo - d1 > 2))
        r1 = d1 + $urandom_range(eo - d1 - 1, 1);
      run_script(div, d1, r1, 0, eo + 2 * (div + 1) + 3);
      if (r1 != 0) check("rand.still_enabled", 32'(pwm_enable), 32'd1);
      reset_sig = 1'b1;
      #2;
      check_outs_zero("async_reset");
      tick();
      reset_sig = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/peridot_servo_stepgen.md
# peridot_servo_stepgen

Frame/step timebase for the PERIDOT RC servo channels. A programmable prescaler generates one `pwm_timing` strobe per step, and a step counter sweeps `step_num` through 0→2559 per 20 ms frame. The block also drives the shared `pwm_enable`, with enable and disable applied only on frame boundaries so no servo ever sees a truncated pulse. It sits directly upstream of every per-channel PWM generator and exposes a small register slave plus a frame interrupt.

## Interface
- `CLOCKFREQ`, default 100000000: `clock_sig` frequency in Hz.
- `STEPFREQ`, default 128000: step rate in Hz (2560 steps × 50 Hz).
- `FRAMESTEPS`, default 2560: steps per frame; `step_num` runs 0…FRAMESTEPS-1; must be ≤ 8192.
- `clock_sig` in 1: clock; the block is clocked on the positive edge only.
- `reset_sig` in 1: reset, asynchronous, active-high.
- `reg_address` in 2: register select.
- `reg_write` in 1: write strobe, one cycle per write.
- `reg_writedata` in 16: write data.
- `reg_readdata` out 16: read data; combinational from `reg_address`, zero wait.
- `pwm_enable` out 1: run gate to all PWM generators.
- `pwm_timing` out 1: one-clock step strobe.
- `step_num` out 13: current step; stable for the whole strobe cycle.
- `frame_start` out 1: one-clock pulse coincident with the `pwm_timing` of step 0.
- `irq` out 1: level frame interrupt.

## Operation
- Registers:
  - Addr 0 CONTROL:
    - bit0 ENABLE (rw).
    - bit1 IRQENA (rw).
    - bit15 RUN (ro) = `pwm_enable`.
  - Addr 1 STATUS: bit0 FRAME, set by hardware, cleared by writing 1.
  - Addr 2 DIV: 16 bit, rw. Strobe period is DIV+1 clocks. Reset value CLOCKFREQ/STEPFREQ-1, i.e. 780 with the defaults.
  - Addr 3 STEP (ro): `step_num`, zero-extended.
  - Unused read bits are 0.
- FSM states IDLE, RUN, DRAIN.
- IDLE:
  - Prescaler is held at DIV; `step_num` = 0; `pwm_timing` = 0; `pwm_enable` = 0.
  - A write of ENABLE=1 moves to RUN; `pwm_enable` = 1 from the next clock.
- RUN:
  - Prescaler counts down from DIV. At 0 it asserts `pwm_timing` for one clock and reloads from the current DIV. A DIV write never cuts a count short; it takes effect at the next reload.
  - On each strobe, `step_num` increments after the strobe cycle and wraps FRAMESTEPS-1 → 0.
  - A write of ENABLE=0 moves to DRAIN.
- DRAIN:
  - Counting continues and `pwm_enable` stays 1.
  - On the strobe with `step_num` = FRAMESTEPS-1, the next state is IDLE. `pwm_enable` drops, and the counters return to their IDLE values on the same edge.
  - A write of ENABLE=1 during DRAIN returns to RUN with no disturbance to the count.
- FRAME is set on every `frame_start`. A set and a clear in the same clock: set wins. `irq` = FRAME & IRQENA.
- Reset mid-frame: all outputs go to their reset values immediately; no drain.

## Timing
- Reset values:
  - `pwm_enable` 0, `pwm_timing` 0, `step_num` 0, `frame_start` 0, `irq` 0.
  - ENABLE 0, IRQENA 0, FRAME 0, DIV = default.
- Register writes take effect on the clock edge after `reg_write`.
- From the ENABLE=1 write, the first strobe (`step_num` 0, `frame_start` 1) occurs DIV+1 clocks after `pwm_enable` rises.
- DIV=0: the strobe is asserted every clock while in RUN or DRAIN.
- All outputs are registered except `reg_readdata`.

## Configuration
- `PERIDOT_SERVO_STEPGEN_IRQ_EN`:
  - Defined: FRAME, IRQENA and `irq` are implemented as described above.
  - Undefined: that logic is removed. `irq` is tied to 0, CONTROL bit1 and STATUS bit0 read as 0, and writes to them are ignored. All timing behaviour is unchanged.

## Test plan
- Reset, read all four registers -> CONTROL 0x0000, STATUS 0, DIV 780, STEP 0; all outputs 0.
- DIV=3, ENABLE=1 -> `pwm_enable` rises next clock; strobes every 4 clocks with `step_num` 0,1,2,…; 2559 is followed by 0, and `frame_start` accompanies each step 0.
- DIV=3, running at step 1000, write ENABLE=0 -> `pwm_enable` stays 1 through the strobe at step 2559, then drops; `step_num` reads 0 and the strobes stop.
- In DRAIN at step 2000, write ENABLE=1 -> no drop at the frame end; step 2559 wraps to 0 with `pwm_enable` held at 1.
- IRQENA=1 -> `irq` rises on the cycle after `frame_start`. Write STATUS=1 on the same clock as the next `frame_start` -> FRAME stays 1. A later clear with no set -> `irq` = 0.
- Write DIV=7 in mid-count at DIV=3 -> the current interval stays 4 clocks; the following intervals are 8 clocks.
